// File: rtl/read_response_engine.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : read_response_engine
// Purpose  : Receiving end of the read engine's CCI read requests. Takes c0
//            read responses and sorts them by mdata tag.
//            - Control-poll responses are decoded into the ctrl_resp_* group.
//            - Run responses are counted against the run length taken from
//              the START_RUN command.
//            - Anything unexpected or out of state goes to a saturating
//              error counter.
//            Two-stage pipeline: S1 registers the inputs and S2 decodes into
//            registered outputs. A response in cycle N shows at cycle N+2.
// Ports    : clk, reset (async, active-high)
//            afu_state_in            current AFU state
//            rsp_valid/mdata/data    c0 read response (no backpressure)
//            ctrl_resp_valid/ack/code/rd_addr/num_cls   decoded control poll
//            run_cls_rcvd            run CLs counted since last START_RUN
//            run_rsp_done            all expected run CLs received (sticky)
//            err_cnt                 unexpected responses (saturating)
//            run_checksum            XOR fold of run CLs (RD_RSP_CHECKSUM_EN)
// Config   : `define RD_RSP_CHECKSUM_EN adds the run_checksum port and logic.
// Revision : 1.0 - initial release
// ============================================================================
module read_response_engine #(
  parameter logic [15:0] CTRL_MDATA        = 16'h0001,
  parameter logic [15:0] RUN_MDATA         = 16'h0002,
  parameter int          ERR_CNT_W         = 16,
  parameter logic [1:0]  AFU_CTRL          = 2'd1,
  parameter logic [1:0]  AFU_RUN           = 2'd2,
  parameter logic [31:0] CONTROL_NONE      = 32'd0,
  parameter logic [31:0] CONTROL_START_RUN = 32'd1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           afu_state_in,
  input  logic                 rsp_valid,
  input  logic [15:0]          rsp_mdata,
  input  logic [511:0]         rsp_data,
  output logic                 ctrl_resp_valid,
  output logic                 ctrl_resp_ack,
  output logic [31:0]          ctrl_resp_code,
  output logic [41:0]          ctrl_resp_rd_addr,
  output logic [31:0]          ctrl_resp_num_cls,
  output logic [31:0]          run_cls_rcvd,
  output logic                 run_rsp_done,
`ifdef RD_RSP_CHECKSUM_EN
  output logic [63:0]          run_checksum,
`endif
  output logic [ERR_CNT_W-1:0] err_cnt
);

  // S1: plain registered copy of everything, state included, so a response
  // is always judged against the state sampled alongside it.
  logic [1:0]   s1_state;
  logic         s1_valid;
  logic [15:0]  s1_mdata;
  logic [511:0] s1_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_state <= '0;
      s1_valid <= 1'b0;
      s1_mdata <= '0;
      s1_data  <= '0;
    end else begin
      s1_state <= afu_state_in;
      s1_valid <= rsp_valid;
      s1_mdata <= rsp_mdata;
      s1_data  <= rsp_data;
    end
  end

  // S2 decode
  logic [31:0] line_code;
  logic [41:0] line_rd_addr;
  logic [31:0] line_num_cls;
  logic        ctrl_ok;
  logic        start_run;
  logic        run_ok;
  logic        rsp_err;
  logic [31:0] cls_next;
  logic [32:0] expected;

  assign line_code    = s1_data[31:0];
  assign line_rd_addr = s1_data[105:64];
  assign line_num_cls = s1_data[159:128];

  assign ctrl_ok   = s1_valid && (s1_mdata == CTRL_MDATA) && (s1_state == AFU_CTRL);
  assign start_run = ctrl_ok && (line_code == CONTROL_START_RUN);
  // Once done, further run CLs are surplus and are treated as errors.
  assign run_ok    = s1_valid && (s1_mdata == RUN_MDATA) && (s1_state == AFU_RUN) &&
                     !run_rsp_done;
  // Only one response per cycle, so at most one error per cycle.
  assign rsp_err   = s1_valid && !ctrl_ok && !run_ok;

  assign cls_next  = (run_cls_rcvd == '1) ? run_cls_rcvd : run_cls_rcvd + 32'd1;

`ifdef RD_RSP_CHECKSUM_EN
  logic [63:0] cl_fold;
  always_comb begin
    cl_fold = '0;
    for (int i = 0; i < 8; i++) begin
      cl_fold = cl_fold ^ s1_data[i*64 +: 64];
    end
  end
`else
  // Payload bits outside the control fields are only needed for the checksum.
  logic unused_data_bits;
  assign unused_data_bits = ^{s1_data[511:160], s1_data[127:106], s1_data[63:32]};
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_resp_valid   <= 1'b0;
      ctrl_resp_ack     <= 1'b0;
      ctrl_resp_code    <= '0;
      ctrl_resp_rd_addr <= '0;
      ctrl_resp_num_cls <= '0;
      run_cls_rcvd      <= '0;
      run_rsp_done      <= 1'b0;
      expected          <= '0;
      err_cnt           <= '0;
`ifdef RD_RSP_CHECKSUM_EN
      run_checksum      <= '0;
`endif
    end else begin
      ctrl_resp_ack   <= ctrl_ok;
      ctrl_resp_valid <= ctrl_ok && (line_code != CONTROL_NONE);

      if (ctrl_ok) begin
        ctrl_resp_code    <= line_code;
        ctrl_resp_rd_addr <= line_rd_addr;
        ctrl_resp_num_cls <= line_num_cls;
      end

      if (start_run) begin
        run_cls_rcvd <= '0;
        run_rsp_done <= 1'b0;
        // Range start..start+num_cls is inclusive; 33 bits holds 2^32.
        expected     <= {1'b0, line_num_cls} + 33'd1;
`ifdef RD_RSP_CHECKSUM_EN
        run_checksum <= '0;
`endif
      end else if (run_ok) begin
        run_cls_rcvd <= cls_next;
        if ({1'b0, cls_next} == expected) begin
          run_rsp_done <= 1'b1;
        end
`ifdef RD_RSP_CHECKSUM_EN
        run_checksum <= run_checksum ^ cl_fold;
`endif
      end

      if (rsp_err && (err_cnt != '1)) begin
        err_cnt <= err_cnt + ERR_CNT_W'(1);
      end
    end
  end

endmodule
`default_nettype wire
